io_mmio_responder: RTL

IO_MMIO_RESPONDER -- requirements
Module: io_mmio_responder

---
 rtl/io_mmio_responder.sv | 166 ++++++++++++++++
 1 files changed

// File: rtl/io_mmio_responder.sv
// io_mmio_responder: CPU-visible MMIO window at 0x8xxxxxxx bridging UART streams and two counters.
// Define MMIO_RX_FIFO_EN to buffer received bytes in an RX_FIFO_DEPTH-entry FIFO instead of one register.

module io_mmio_responder #(
    parameter int RX_FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_en,
    input  logic [3:0]  req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic [31:0] rdata,
    output logic        addr_hit,
    input  logic        inst_retire,
    input  logic [7:0]  uart_rx_data,
    input  logic        uart_rx_valid,
    output logic        uart_rx_ready,
    output logic [7:0]  uart_tx_data,
    output logic        uart_tx_valid,
    input  logic        uart_tx_ready
);

    localparam logic [31:0] ADDR_STATUS = 32'h8000_0000;
    localparam logic [31:0] ADDR_RX     = 32'h8000_0004;
    localparam logic [31:0] ADDR_TX     = 32'h8000_0008;
    localparam logic [31:0] ADDR_CYCLE  = 32'h8000_0010;
    localparam logic [31:0] ADDR_INSTR  = 32'h8000_0014;
    localparam logic [31:0] ADDR_CLEAR  = 32'h8000_0018;

    if (RX_FIFO_DEPTH < 2 || (RX_FIFO_DEPTH & (RX_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("RX_FIFO_DEPTH must be a power of two >= 2");
    end

    logic        load;
    logic        store;
    logic        rx_push;
    logic        rx_pop;
    logic        rx_full;
    logic        rx_avail;
    logic [7:0]  rx_head;
    logic [31:0] cycle_cnt;
    logic [31:0] inst_cnt;
    logic [31:0] load_value;
    logic        unused_wdata;

    assign addr_hit     = (req_addr[31:28] == 4'h8);
    assign load         = req_en && addr_hit && (req_we == 4'b0000);
    assign store        = req_en && addr_hit && (req_we != 4'b0000);
    assign unused_wdata = ^req_wdata[31:8];

    assign uart_rx_ready = ~rx_full;
    assign rx_push       = uart_rx_valid && uart_rx_ready;
    assign rx_pop        = load && (req_addr == ADDR_RX) && rx_avail;

`ifdef MMIO_RX_FIFO_EN
    localparam int PTR_W = $clog2(RX_FIFO_DEPTH);

    logic [7:0]       rx_mem [RX_FIFO_DEPTH];
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W:0]   rx_count;

    assign rx_full  = (rx_count == (PTR_W + 1)'(RX_FIFO_DEPTH));
    assign rx_avail = (rx_count != '0);
    assign rx_head  = rx_mem[rd_ptr];

    // NOTE: the storage array has no reset; rx_count alone decides which entries are valid.
    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[wr_ptr] <= uart_rx_data;
        end
    end

    // Pointers wrap naturally because the depth is a power of two.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            rx_count <= '0;
        end else begin
            if (rx_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (rx_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({rx_push, rx_pop})
                2'b10:   rx_count <= rx_count + (PTR_W + 1)'(1);
                2'b01:   rx_count <= rx_count - (PTR_W + 1)'(1);
                default: rx_count <= rx_count;
            endcase
        end
    end
`else
    logic       rx_held;
    logic [7:0] rx_byte;

    assign rx_full  = rx_held;
    assign rx_avail = rx_held;
    assign rx_head  = rx_byte;

    // Push needs an empty slot and pop needs a full one, so they never coincide here.
    always_ff @(posedge clk) begin
        if (rst) begin
            rx_held <= 1'b0;
            rx_byte <= '0;
        end else if (rx_push) begin
            rx_held <= 1'b1;
            rx_byte <= uart_rx_data;
        end else if (rx_pop) begin
            rx_held <= 1'b0;
        end
    end
`endif

    // A store landing while a byte is still pending is dropped, even on the handshake edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            uart_tx_valid <= 1'b0;
            uart_tx_data  <= '0;
        end else if (store && (req_addr == ADDR_TX) && req_we[0] && !uart_tx_valid) begin
            uart_tx_valid <= 1'b1;
            uart_tx_data  <= req_wdata[7:0];
        end else if (uart_tx_valid && uart_tx_ready) begin
            uart_tx_valid <= 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else if (store && (req_addr == ADDR_CLEAR)) begin
            cycle_cnt <= '0;
            inst_cnt  <= '0;
        end else begin
            cycle_cnt <= cycle_cnt + 32'd1;
            if (inst_retire) begin
                inst_cnt <= inst_cnt + 32'd1;
            end
        end
    end

    // NOTE: the default assignment up front keeps this block from inferring a latch.
    always_comb begin
        load_value = '0;
        case (req_addr)
            ADDR_STATUS: load_value = {30'b0, rx_avail, ~uart_tx_valid};
            ADDR_RX:     load_value = rx_avail ? {24'b0, rx_head} : 32'b0;
            ADDR_CYCLE:  load_value = cycle_cnt;
            ADDR_INSTR:  load_value = inst_cnt;
            default:     load_value = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata <= '0;
        end else if (load) begin
            rdata <= load_value;
        end
    end

endmodule
